// File: rtl/omi_lane_pkg.sv
// Shared lane-lock types: FSM state encoding, legal sync headers and header classifier.
package omi_lane_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        WAIT   = 2'd1,
        LOCKED = 2'd2
    } lane_state_e;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    function automatic logic is_good_header(input logic [1:0] hdr);
        return (hdr == SH_DATA) || (hdr == SH_CTRL);
    endfunction

endpackage

// File: rtl/omi_sat_counter.sv
// Saturating event counter; reached_c flags the increment that lands on MAX (or MAX already held).
module omi_sat_counter #(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic reached_c
);

    localparam int unsigned W = $clog2(MAX + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != W'(MAX))) begin
            count <= count + W'(1);
        end
    end

    assign reached_c = inc ? (count >= W'(MAX - 1)) : (count == W'(MAX));

endmodule

// File: rtl/omi_rx_lane_lock.sv
// Per-lane RX block-lock controller: slips the gearbox until sync headers are stable, forwards beats while locked.
// Optional OMI_RX_LOCK_STATS_EN adds saturating slip_count / lock_loss_count outputs.
module omi_rx_lane_lock
    import omi_lane_pkg::*;
#(
    parameter int unsigned PHY_BITS  = 8,
    parameter int unsigned GOOD_MAX  = 64,
    parameter int unsigned WIN_LEN   = 1024,
    parameter int unsigned BAD_MAX   = 16,
    parameter int unsigned SLIP_WAIT = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                phy_rx_valid,
    input  logic [1:0]          phy_rx_header,
    input  logic [PHY_BITS-1:0] phy_rx_data,
    output logic                phy_rx_slip,
    output logic                ln_rx_valid,
    output logic [1:0]          ln_rx_header,
    output logic [PHY_BITS-1:0] ln_rx_data,
    input  logic                ln_rx_slip,
    output logic                locked
`ifdef OMI_RX_LOCK_STATS_EN
    ,
    output logic [15:0]         slip_count,
    output logic [15:0]         lock_loss_count
`endif
);

    lane_state_e state, state_d;
    logic        pend_q, pend_d;
    logic        slip_d, lock_loss_d, valid_d;
    logic        good_c, good_inc, hdr_inc, bad_inc, wait_inc;
    logic        good_clr, hdr_clr, wait_clr;
    logic        good_hit, hdr_hit, bad_hit, wait_hit;
    logic        bad_loss, win_end;

    assign good_c   = is_good_header(phy_rx_header);
    assign good_inc = (state == HUNT) && phy_rx_valid && good_c;
    assign hdr_inc  = (state == LOCKED) && phy_rx_valid;
    assign bad_inc  = hdr_inc && !good_c;
    assign wait_inc = (state == WAIT);
    assign bad_loss = bad_inc && bad_hit;
    assign win_end  = hdr_inc && hdr_hit && !bad_loss;

    // A repeated slip during settle restarts the wait; the pulse itself is issued once the wait completes.
    assign good_clr = (state != HUNT);
    assign hdr_clr  = (state != LOCKED) || win_end;
    assign wait_clr = (state != WAIT) || ln_rx_slip || slip_d;

    omi_sat_counter #(.MAX(GOOD_MAX)) u_good_cnt (
        .clk(clk), .rst_n(rst_n), .clear(good_clr), .inc(good_inc), .reached_c(good_hit)
    );
    omi_sat_counter #(.MAX(SLIP_WAIT)) u_wait_cnt (
        .clk(clk), .rst_n(rst_n), .clear(wait_clr), .inc(wait_inc), .reached_c(wait_hit)
    );
    omi_sat_counter #(.MAX(WIN_LEN)) u_hdr_cnt (
        .clk(clk), .rst_n(rst_n), .clear(hdr_clr), .inc(hdr_inc), .reached_c(hdr_hit)
    );
    omi_sat_counter #(.MAX(BAD_MAX)) u_bad_cnt (
        .clk(clk), .rst_n(rst_n), .clear(hdr_clr), .inc(bad_inc), .reached_c(bad_hit)
    );

    always_comb begin
        state_d     = state;
        pend_d      = pend_q;
        slip_d      = 1'b0;
        lock_loss_d = 1'b0;
        unique case (state)
            HUNT: begin
                if (ln_rx_slip || (phy_rx_valid && !good_c)) begin
                    slip_d  = 1'b1;
                    state_d = WAIT;
                end else if (good_inc && good_hit) begin
                    state_d = LOCKED;
                end
            end
            WAIT: begin
                if (ln_rx_slip) begin
                    pend_d = 1'b1;
                end else if (wait_hit) begin
                    if (pend_q) begin
                        slip_d = 1'b1;
                        pend_d = 1'b0;
                    end else begin
                        state_d = HUNT;
                    end
                end
            end
            LOCKED: begin
                if (ln_rx_slip || bad_loss) begin
                    slip_d      = 1'b1;
                    lock_loss_d = 1'b1;
                    state_d     = WAIT;
                end
            end
            default: state_d = HUNT;
        endcase
        valid_d = hdr_inc && !lock_loss_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HUNT;
            pend_q       <= 1'b0;
            phy_rx_slip  <= 1'b0;
            ln_rx_valid  <= 1'b0;
            ln_rx_header <= '0;
            ln_rx_data   <= '0;
            locked       <= 1'b0;
        end else begin
            state       <= state_d;
            pend_q      <= pend_d;
            phy_rx_slip <= slip_d;
            ln_rx_valid <= valid_d;
            locked      <= (state_d == LOCKED);
            if (phy_rx_valid) begin
                ln_rx_header <= phy_rx_header;
                ln_rx_data   <= phy_rx_data;
            end
        end
    end

`ifdef OMI_RX_LOCK_STATS_EN
    localparam int unsigned STAT_W = 16;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slip_count      <= '0;
            lock_loss_count <= '0;
        end else begin
            if (slip_d && (slip_count != {STAT_W{1'b1}})) begin
                slip_count <= slip_count + STAT_W'(1);
            end
            if (lock_loss_d && (lock_loss_count != {STAT_W{1'b1}})) begin
                lock_loss_count <= lock_loss_count + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_omi_rx_lane_lock.sv
// Self-checking bench for omi_rx_lane_lock: directed scenarios plus randomized traffic against a cycle-indexed model.
module tb_omi_rx_lane_lock;

    localparam int unsigned PHY_BITS  = 8;
    localparam int unsigned GOOD_MAX  = 4;
    localparam int unsigned WIN_LEN   = 16;
    localparam int unsigned BAD_MAX   = 3;
    localparam int unsigned SLIP_WAIT = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       phy_rx_valid = 1'b0;
    logic [1:0] phy_rx_header = 2'b00;
    logic [7:0] phy_rx_data = 8'h00;
    logic       ln_rx_slip = 1'b0;
    logic       phy_rx_slip;
    logic       ln_rx_valid;
    logic [1:0] ln_rx_header;
    logic [7:0] ln_rx_data;
    logic       locked;
`ifdef OMI_RX_LOCK_STATS_EN
    logic [15:0] slip_count;
    logic [15:0] lock_loss_count;
`endif

    omi_rx_lane_lock #(
        .PHY_BITS(PHY_BITS), .GOOD_MAX(GOOD_MAX), .WIN_LEN(WIN_LEN),
        .BAD_MAX(BAD_MAX), .SLIP_WAIT(SLIP_WAIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .phy_rx_valid(phy_rx_valid), .phy_rx_header(phy_rx_header), .phy_rx_data(phy_rx_data),
        .phy_rx_slip(phy_rx_slip),
        .ln_rx_valid(ln_rx_valid), .ln_rx_header(ln_rx_header), .ln_rx_data(ln_rx_data),
        .ln_rx_slip(ln_rx_slip),
        .locked(locked)
`ifdef OMI_RX_LOCK_STATS_EN
        , .slip_count(slip_count), .lock_loss_count(lock_loss_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    bit chk_en = 1'b0;

    // Model: cycle index k, wait window as an absolute end cycle, lock window as plain tallies.
    int   k = 0;
    int   settle_end = -1;
    int   run = 0;
    int   wbeats = 0;
    int   wbad = 0;
    bit   m_lock = 1'b0;
    bit   pend = 1'b0;
    int   n_slip = 0;
    int   n_loss = 0;
    bit   exp_slip = 1'b0;
    bit   exp_valid = 1'b0;
    bit   exp_locked = 1'b0;
    logic [1:0] exp_hdr = 2'b00;
    logic [7:0] exp_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic issue_slip();
        exp_slip   = 1'b1;
        n_slip++;
        settle_end = k + int'(SLIP_WAIT);
    endtask

    task automatic model_reset();
        settle_end = -1; run = 0; wbeats = 0; wbad = 0;
        m_lock = 1'b0; pend = 1'b0; n_slip = 0; n_loss = 0;
        exp_slip = 1'b0; exp_valid = 1'b0; exp_locked = 1'b0;
        exp_hdr = 2'b00; exp_data = 8'h00;
    endtask

    task automatic model_update(input bit v, input logic [1:0] h, input logic [7:0] d, input bit hs);
        bit good;
        bit lose;
        good      = (h == 2'b01) || (h == 2'b10);
        exp_slip  = 1'b0;
        exp_valid = 1'b0;
        if (v) begin
            exp_hdr  = h;
            exp_data = d;
        end
        if (k <= settle_end) begin
            if (hs) begin
                pend       = 1'b1;
                settle_end = k + int'(SLIP_WAIT);
            end else if (k == settle_end && pend) begin
                pend = 1'b0;
                issue_slip();
            end
        end else if (m_lock) begin
            lose = hs;
            if (v) begin
                wbeats++;
                if (!good) wbad++;
                if (wbad >= int'(BAD_MAX)) lose = 1'b1;
                else if (wbeats >= int'(WIN_LEN)) begin
                    wbeats = 0;
                    wbad   = 0;
                end
            end
            if (lose) begin
                m_lock = 1'b0;
                n_loss++;
                issue_slip();
            end else begin
                exp_valid = v;
            end
        end else begin
            if (hs || (v && !good)) begin
                run = 0;
                issue_slip();
            end else if (v) begin
                run++;
                if (run >= int'(GOOD_MAX)) begin
                    m_lock = 1'b1;
                    run = 0; wbeats = 0; wbad = 0;
                end
            end
        end
        exp_locked = m_lock;
        k++;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("phy_rx_slip", 32'(phy_rx_slip), 32'(exp_slip));
            chk("ln_rx_valid", 32'(ln_rx_valid), 32'(exp_valid));
            chk("locked", 32'(locked), 32'(exp_locked));
            if (exp_valid) begin
                chk("ln_rx_header", 32'(ln_rx_header), 32'(exp_hdr));
                chk("ln_rx_data", 32'(ln_rx_data), 32'(exp_data));
            end
`ifdef OMI_RX_LOCK_STATS_EN
            chk("slip_count", 32'(slip_count), 32'(n_slip));
            chk("lock_loss_count", 32'(lock_loss_count), 32'(n_loss));
`endif
        end
    end

    task automatic step(input bit v, input logic [1:0] h, input logic [7:0] d, input bit hs);
        phy_rx_valid  = v;
        phy_rx_header = h;
        phy_rx_data   = d;
        ln_rx_slip    = hs;
        model_update(v, h, d, hs);
        @(negedge clk);
        #1;
        pulses += int'(phy_rx_slip);
    endtask

    task automatic do_reset();
        phy_rx_valid = 1'b0; phy_rx_header = 2'b00; phy_rx_data = 8'h00; ln_rx_slip = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_slip", 32'(phy_rx_slip), 32'(0));
        chk("rst_valid", 32'(ln_rx_valid), 32'(0));
        chk("rst_locked", 32'(locked), 32'(0));
        chk("rst_header", 32'(ln_rx_header), 32'(0));
        chk("rst_data", 32'(ln_rx_data), 32'(0));
`ifdef OMI_RX_LOCK_STATS_EN
        chk("rst_slip_count", 32'(slip_count), 32'(0));
        chk("rst_loss_count", 32'(lock_loss_count), 32'(0));
`endif
        model_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int badpct[4] = '{0, 3, 10, 40};
        bit v;
        bit hs;
        logic [1:0] h;

        #2;
        do_reset();
        chk_en = 1'b1;

        // Acquire lock with four data headers, then forward one control beat.
        for (int i = 0; i < 3; i++) step(1'b1, 2'b01, 8'(i), 1'b0);
        chk("s1_not_yet_locked", 32'(locked), 32'(0));
        step(1'b1, 2'b01, 8'h03, 1'b0);
        chk("s1_locked", 32'(locked), 32'(1));
        chk("s1_no_slip", 32'(phy_rx_slip), 32'(0));
        step(1'b1, 2'b10, 8'hA5, 1'b0);
        chk("s1_fwd_valid", 32'(ln_rx_valid), 32'(1));
        chk("s1_fwd_data", 32'(ln_rx_data), 32'(8'hA5));
        chk("s1_fwd_header", 32'(ln_rx_header), 32'(2'b10));

        // Third bad header within the window drops lock.
        pulses = 0;
        for (int i = 1; i <= 7; i++) step(1'b1, (i == 2 || i == 5) ? 2'b11 : 2'b01, 8'(8'h10 + i), 1'b0);
        chk("s3_still_locked", 32'(locked), 32'(1));
        step(1'b1, 2'b00, 8'h18, 1'b0);
        chk("s3_slip", 32'(phy_rx_slip), 32'(1));
        chk("s3_unlocked", 32'(locked), 32'(0));
        chk("s3_bad_not_fwd", 32'(ln_rx_valid), 32'(0));
        step(1'b1, 2'b01, 8'h19, 1'b0);
        step(1'b1, 2'b01, 8'h1A, 1'b0);
        chk("s3_one_pulse", 32'(pulses), 32'(1));

        // Bad header in HUNT slips; beats during settle are ignored.
        for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 8'h00, 1'b0);
        step(1'b1, 2'b01, 8'h20, 1'b0);
        step(1'b1, 2'b11, 8'h21, 1'b0);
        chk("s2_slip", 32'(phy_rx_slip), 32'(1));
        pulses = 0;
        for (int i = 0; i < 5; i++) step(1'b1, 2'b11, 8'h22, 1'b0);
        chk("s2_settle_no_pulse", 32'(pulses), 32'(0));
        for (int i = 0; i < 4; i++) step(1'b1, 2'b10, 8'(8'h30 + i), 1'b0);
        chk("s2_relocked", 32'(locked), 32'(1));

        // Two bad per window over four windows keeps lock.
        pulses = 0;
        for (int w = 0; w < 4; w++)
            for (int i = 0; i < 16; i++)
                step(1'b1, (i == 3 || i == 11) ? 2'b00 : 2'b01, 8'($urandom), 1'b0);
        chk("s4_held", 32'(locked), 32'(1));
        chk("s4_no_slip", 32'(pulses), 32'(0));

        // Host slip coincident with the internal loss, then a second request while settling.
        step(1'b1, 2'b11, 8'h40, 1'b0);
        step(1'b1, 2'b01, 8'h41, 1'b0);
        step(1'b1, 2'b11, 8'h42, 1'b0);
        pulses = 0;
        step(1'b1, 2'b00, 8'h43, 1'b1);
        chk("s5_single_pulse", 32'(pulses), 32'(1));
        chk("s5_unlocked", 32'(locked), 32'(0));
        step(1'b0, 2'b00, 8'h00, 1'b0);
        step(1'b0, 2'b00, 8'h00, 1'b1);
        pulses = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 8'h44, 1'b0);
        chk("s5_spacing", 32'(pulses), 32'(0));
        step(1'b1, 2'b01, 8'h45, 1'b0);
        chk("s5_deferred_pulse", 32'(phy_rx_slip), 32'(1));
        for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 8'h46, 1'b0);
        chk("s5_still_settling", 32'(locked), 32'(0));
        for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 8'h47, 1'b0);
        chk("s5_relocked", 32'(locked), 32'(1));
`ifdef OMI_RX_LOCK_STATS_EN
        chk("stats_slips", 32'(slip_count), 32'(4));
        chk("stats_losses", 32'(lock_loss_count), 32'(2));
`endif

        // Asynchronous reset while settling.
        step(1'b0, 2'b00, 8'h00, 1'b1);
        chk("s6_slip", 32'(phy_rx_slip), 32'(1));
        step(1'b0, 2'b00, 8'h00, 1'b0);
        do_reset();
        step(1'b1, 2'b01, 8'h50, 1'b0);
        chk("s6_hunting", 32'(locked), 32'(0));

        // Randomized traffic with varying error density.
        for (int seg = 0; seg < 4; seg++) begin
            if (seg == 2) do_reset();
            for (int i = 0; i < 600; i++) begin
                v = ($urandom_range(99) < 80);
                if ($urandom_range(99) < badpct[seg]) h = ($urandom_range(1) == 1) ? 2'b11 : 2'b00;
                else h = ($urandom_range(1) == 1) ? 2'b01 : 2'b10;
                hs = ($urandom_range(149) == 0);
                step(v, h, 8'($urandom), hs);
            end
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
